// File: rtl/lpc_record_fifo_pkg.sv
// Shared definitions for the LPC record FIFO: record layout, sizes and
// serializer state encoding.
package lpc_record_fifo_pkg;

  localparam int REC_W         = 32;
  localparam int BYTES_PER_REC = 4;

  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int RSVD_LSB = 24;
  localparam int TO_BIT   = 26;
  localparam int LOST_BIT = 27;
  localparam int CYC_LSB  = 28;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Record word: {cyctype_dir, lost, sync_timeout, 2'b00, addr[15:0], data}
  function automatic logic [REC_W-1:0] pack_record(
    input logic [3:0]  cyc,
    input logic        lost,
    input logic        timeout,
    input logic [15:0] addr,
    input logic [7:0]  data
  );
    return {cyc, lost, timeout, 2'b00, addr, data};
  endfunction

endpackage

// File: rtl/lpc_record_fifo_if.sv
// Bundles the decoder-side record inputs and the byte stream toward the UART.
interface lpc_record_fifo_if;

  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        in_sync_timeout;
  logic        in_clock_enable;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_cyctype_dir, in_addr, in_data, in_sync_timeout, in_clock_enable,
    output out_ready,
    input  out_byte, out_valid
  );

  modport slave (
    input  in_cyctype_dir, in_addr, in_data, in_sync_timeout, in_clock_enable,
    input  out_ready,
    output out_byte, out_valid
  );

endinterface

// File: rtl/lpc_record_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the caller guarantees push only
// when there is room (or a pop in the same cycle) and pop only when non-empty.
module lpc_record_fifo_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   lpc_clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  always_ff @(posedge lpc_clock) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; occupancy lives in r_level.
  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/lpc_record_fifo.sv
// Captures completed LPC I/O reads into a record FIFO and serializes each
// record as four bytes on a valid/ready stream, counting dropped records.
module lpc_record_fifo
  import lpc_record_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                   lpc_clock,
  input  logic                   reset,
  lpc_record_fifo_if.slave       bus,
  output logic [CNT_W-1:0]       o_overflow_count,
  output logic [$clog2(DEPTH):0] o_fifo_level
);

  localparam int         LW         = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [1:0] LAST_IDX   = 2'(BYTES_PER_REC - 1);

  logic             r_en_q;
  logic             r_lost;
  logic [CNT_W-1:0] r_overflow;
  ser_state_e       r_state;
  logic [1:0]       r_idx;
  logic [REC_W-1:0] r_rec;

  logic             w_cap;
  logic             w_accept;
  logic             w_pop;
  logic             w_has_data;
  logic             w_handshake;
  logic [LW-1:0]    w_level;
  logic [REC_W-1:0] w_rec_in;
  logic [REC_W-1:0] w_fifo_dout;
  ser_state_e       w_state_nxt;
  logic [1:0]       w_idx_nxt;
  logic [7:0]       w_byte;
  logic             w_unused_addr;
  logic [1:0]       w_unused_rsvd;

  assign w_cap      = bus.in_clock_enable & ~r_en_q;
  assign w_has_data = (w_level != '0);
  assign w_accept   = w_cap & ((w_level < FULL_LEVEL) | w_pop);
  assign w_rec_in   = pack_record(bus.in_cyctype_dir, r_lost, bus.in_sync_timeout,
                                  bus.in_addr[15:0], bus.in_data);

  assign w_unused_addr = ^bus.in_addr[31:16];
  assign w_unused_rsvd = r_rec[RSVD_LSB +: 2];

  lpc_record_fifo_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .lpc_clock (lpc_clock),
    .reset     (reset),
    .i_push    (w_accept),
    .i_pop     (w_pop),
    .i_data    (w_rec_in),
    .o_data    (w_fifo_dout),
    .o_level   (w_level)
  );

  // en_q resets high so an enable already asserted at reset exit is not a new record.
  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      r_en_q     <= 1'b1;
      r_lost     <= 1'b0;
      r_overflow <= '0;
    end else begin
      r_en_q <= bus.in_clock_enable;
      if (w_cap) begin
        if (w_accept) begin
          r_lost <= 1'b0;
        end else begin
          r_lost <= 1'b1;
          if (r_overflow != {CNT_W{1'b1}}) r_overflow <= r_overflow + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_rec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) r_rec <= w_fifo_dout;
    end
  end

  // After the last byte, reload straight from the FIFO so queued records stream without a gap.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    w_handshake = (r_state == ST_SEND) & bus.out_ready;
    case (r_state)
      ST_IDLE: begin
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
          w_idx_nxt   = 2'd0;
        end
      end
      ST_SEND: begin
        if (w_handshake) begin
          if (r_idx != LAST_IDX) begin
            w_idx_nxt = r_idx + 2'd1;
          end else if (w_has_data) begin
            w_pop     = 1'b1;
            w_idx_nxt = 2'd0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 2'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      2'd0:    w_byte = {r_rec[CYC_LSB +: 4], 2'b00, r_rec[TO_BIT], r_rec[LOST_BIT]};
      2'd1:    w_byte = r_rec[ADDR_LSB + 8 +: 8];
      2'd2:    w_byte = r_rec[ADDR_LSB +: 8];
      default: w_byte = r_rec[DATA_LSB +: 8];
    endcase
  end

  assign bus.out_valid    = (r_state == ST_SEND);
  assign bus.out_byte     = (r_state == ST_SEND) ? w_byte : 8'h00;
  assign o_overflow_count = r_overflow;
  assign o_fifo_level     = w_level;

endmodule

// File: tb/tb_lpc_record_fifo.sv
// Directed self-checking bench for lpc_record_fifo: a DEPTH=16/CNT_W=8 instance
// for the main scenarios and a DEPTH=2/CNT_W=2 instance for counter saturation.
module tb_lpc_record_fifo;

  logic lpc_clock = 1'b0;
  logic reset     = 1'b1;

  lpc_record_fifo_if bus0 ();
  lpc_record_fifo_if bus1 ();

  logic [7:0] ovf0;
  logic [4:0] lvl0;
  logic [1:0] ovf1;
  logic [1:0] lvl1;

  int testsRun    = 0;
  int testsFailed = 0;

  lpc_record_fifo #(.DEPTH(16), .CNT_W(8)) u_dut (
    .lpc_clock        (lpc_clock),
    .reset            (reset),
    .bus              (bus0),
    .o_overflow_count (ovf0),
    .o_fifo_level     (lvl0)
  );

  lpc_record_fifo #(.DEPTH(2), .CNT_W(2)) u_dut_sat (
    .lpc_clock        (lpc_clock),
    .reset            (reset),
    .bus              (bus1),
    .o_overflow_count (ovf1),
    .o_fifo_level     (lvl1)
  );

  always #5 lpc_clock = ~lpc_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task tick;
    @(posedge lpc_clock);
    #1;
  endtask

  // One record: enable rises before edge N, falls before edge N+1; returns just after N+1.
  task automatic applyStimulus(input logic [3:0] cyc, input logic [15:0] addr,
                               input logic [7:0] data, input logic timeout);
    bus0.in_cyctype_dir  = cyc;
    bus0.in_addr         = {16'hDEAD, addr};
    bus0.in_data         = data;
    bus0.in_sync_timeout = timeout;
    bus0.in_clock_enable = 1'b1;
    tick();
    bus0.in_clock_enable = 1'b0;
    tick();
  endtask

  task automatic applyStimulusSat(input logic [7:0] data);
    bus1.in_cyctype_dir  = 4'h0;
    bus1.in_addr         = 32'h0;
    bus1.in_data         = data;
    bus1.in_sync_timeout = 1'b0;
    bus1.in_clock_enable = 1'b1;
    tick();
    bus1.in_clock_enable = 1'b0;
    tick();
  endtask

  // With out_ready high, the currently presented record must stream out in four cycles.
  task automatic expectRecord(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] expBytes [4];
    expBytes = '{b0, b1, b2, b3};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s_valid%0d", tag, k), bus0.out_valid, 1);
      checkOutput($sformatf("%s_b%0d", tag, k), bus0.out_byte, expBytes[k]);
      tick();
    end
    checkOutput({tag, "_idle"}, bus0.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] burst [12];
    int byteCount;
    int recNo;

    bus0.in_cyctype_dir = 4'h0; bus0.in_addr = 32'h0; bus0.in_data = 8'h0;
    bus0.in_sync_timeout = 1'b0; bus0.in_clock_enable = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_cyctype_dir = 4'h0; bus1.in_addr = 32'h0; bus1.in_data = 8'h0;
    bus1.in_sync_timeout = 1'b0; bus1.in_clock_enable = 1'b0; bus1.out_ready = 1'b0;

    reset = 1'b1;
    repeat (3) tick();
    checkOutput("rst_valid", bus0.out_valid, 0);
    checkOutput("rst_byte", bus0.out_byte, 8'h00);
    checkOutput("rst_level", lvl0, 0);
    checkOutput("rst_ovf", ovf0, 0);
    reset = 1'b0;
    tick();

    // Single record with latency: pushed at N, popped at N+1, first handshake at N+2.
    bus0.out_ready       = 1'b1;
    bus0.in_cyctype_dir  = 4'h0;
    bus0.in_addr         = 32'h0000_0080;
    bus0.in_data         = 8'h5A;
    bus0.in_sync_timeout = 1'b0;
    bus0.in_clock_enable = 1'b1;
    tick();
    checkOutput("t1_valid_N", bus0.out_valid, 0);
    checkOutput("t1_level_N", lvl0, 1);
    bus0.in_clock_enable = 1'b0;
    tick();
    checkOutput("t1_level_N1", lvl0, 0);
    expectRecord("t1", 8'h00, 8'h00, 8'h80, 8'h5A);

    // Backpressure after b1 is accepted: b2 must hold for the whole stall.
    applyStimulus(4'h2, 16'h0080, 8'h5A, 1'b1);
    checkOutput("t2_b0", bus0.out_byte, 8'h22);
    tick();
    checkOutput("t2_b1", bus0.out_byte, 8'h00);
    tick();
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("t2_hold_valid", bus0.out_valid, 1);
      checkOutput("t2_hold_b2", bus0.out_byte, 8'h80);
      tick();
    end
    bus0.out_ready = 1'b1;
    checkOutput("t2_resume_b2", bus0.out_byte, 8'h80);
    tick();
    checkOutput("t2_resume_b3", bus0.out_byte, 8'h5A);
    tick();
    checkOutput("t2_idle", bus0.out_valid, 0);

    // Overflow: record 1 sits in the serializer, 2..17 fill the FIFO, 18 and 19 drop.
    bus0.out_ready = 1'b0;
    for (int i = 1; i <= 19; i++) applyStimulus(4'h1, 16'(i), 8'(i), 1'b0);
    checkOutput("t3_level_full", lvl0, 16);
    checkOutput("t3_ovf", ovf0, 2);
    bus0.out_ready = 1'b1;
    byteCount = 0;
    recNo = 1;
    for (int c = 0; c < 200 && bus0.out_valid; c++) begin
      if (byteCount % 4 == 0) checkOutput("t3_drain_b0", bus0.out_byte, 8'h10);
      if (byteCount % 4 == 3) begin
        checkOutput("t3_drain_seq", bus0.out_byte, 8'(recNo));
        recNo++;
      end
      byteCount++;
      tick();
    end
    checkOutput("t3_drain_count", byteCount, 68);
    checkOutput("t3_level_empty", lvl0, 0);
    applyStimulus(4'h0, 16'h1234, 8'hAA, 1'b0);
    expectRecord("t3_lost_set", 8'h01, 8'h12, 8'h34, 8'hAA);
    applyStimulus(4'h0, 16'h1234, 8'hAB, 1'b0);
    expectRecord("t3_lost_clr", 8'h00, 8'h12, 8'h34, 8'hAB);
    checkOutput("t3_ovf_hold", ovf0, 2);

    // Back-to-back: three queued records must stream as 12 contiguous bytes.
    bus0.out_ready = 1'b0;
    applyStimulus(4'h1, 16'h0102, 8'h03, 1'b0);
    applyStimulus(4'h3, 16'hABCD, 8'hEF, 1'b1);
    applyStimulus(4'hF, 16'h00FF, 8'h00, 1'b0);
    checkOutput("t4_level", lvl0, 2);
    burst = '{8'h10, 8'h01, 8'h02, 8'h03,
              8'h32, 8'hAB, 8'hCD, 8'hEF,
              8'hF0, 8'h00, 8'hFF, 8'h00};
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("t4_valid%0d", k), bus0.out_valid, 1);
      checkOutput($sformatf("t4_byte%0d", k), bus0.out_byte, burst[k]);
      tick();
    end
    checkOutput("t4_idle", bus0.out_valid, 0);

    // Reset mid-SEND with enable held high across reset deassertion.
    bus0.out_ready = 1'b0;
    applyStimulus(4'h3, 16'h5555, 8'h66, 1'b0);
    applyStimulus(4'h3, 16'h5555, 8'h66, 1'b0);
    checkOutput("t5_pre_level", lvl0, 1);
    checkOutput("t5_pre_valid", bus0.out_valid, 1);
    checkOutput("t5_pre_ovf", ovf0, 2);
    bus0.in_clock_enable = 1'b1;
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_valid", bus0.out_valid, 0);
    checkOutput("t5_rst_byte", bus0.out_byte, 8'h00);
    checkOutput("t5_rst_level", lvl0, 0);
    checkOutput("t5_rst_ovf", ovf0, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    checkOutput("t5_nocap_level", lvl0, 0);
    checkOutput("t5_nocap_valid", bus0.out_valid, 0);
    bus0.in_clock_enable = 1'b0;
    tick();
    bus0.out_ready = 1'b1;
    applyStimulus(4'h3, 16'h5555, 8'h66, 1'b0);
    expectRecord("t5_after", 8'h30, 8'h55, 8'h55, 8'h66);

    // Saturation on the narrow instance: one in serializer, two queued, then six drops.
    applyStimulusSat(8'h01);
    applyStimulusSat(8'h02);
    applyStimulusSat(8'h03);
    checkOutput("t6_level", lvl1, 2);
    checkOutput("t6_ovf0", ovf1, 0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulusSat(8'(k + 3));
      checkOutput($sformatf("t6_ovf_drop%0d", k), ovf1, (k < 3) ? k : 3);
    end
    checkOutput("t6_level_end", lvl1, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
